// File: rtl/chip8_program_loader_pkg.sv
// Shared types and defaults for the Chip-8 program loader.
package chip8_program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  localparam logic [11:0] DEFAULT_LOAD_BASE  = 12'h200;
  localparam int unsigned DEFAULT_RESET_HOLD = 16;
  localparam logic [11:0] ADDR_TOP           = 12'hFFF;

endpackage

// File: rtl/chip8_program_loader_sync_edge.sv
// Two-flop synchroniser with edge detection; pulses appear the third clk after the input edge.
module loader_sync_edge (
  input  logic clk,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  // Left without reset so a level still high across res does not look like a fresh edge.
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    sh <= {sh[1:0], d};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];
  assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/chip8_program_loader.sv
// Copies a data_io ROM upload into Chip-8 RAM, optionally clearing program RAM first,
// and holds the CPU in reset while loading and for a short time afterwards.
module chip8_program_loader
  import chip8_program_loader_pkg::*;
#(
  parameter logic [11:0] LOAD_BASE      = DEFAULT_LOAD_BASE,
  parameter logic        CLEAR_ON_START = 1'b1,
  parameter int unsigned RESET_HOLD     = DEFAULT_RESET_HOLD
) (
  input  logic        clk,
  input  logic        res,
  input  logic        uploading,
  input  logic        upload_clk,
  input  logic        upload_en,
  input  logic [11:0] upload_a,
  input  logic [7:0]  upload_d,
  output logic        mem_busy,
  output logic        mem_we,
  output logic [11:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        cpu_res,
  output logic [11:0] bytes_loaded,
  output logic        overflow
);

  localparam state_t      START_STATE = CLEAR_ON_START ? ST_CLEAR : ST_LOAD;
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD - 1);

  state_t      state, state_nxt;
  logic        up_level, up_rise, up_fall;
  logic        stb_level, stb_rise, stb_fall;
  logic        sync_unused;
  logic [11:0] clr_a;
  logic        pend_valid;
  logic [11:0] pend_a;
  logic [7:0]  pend_d;
  logic [15:0] hold_cnt;
  logic        start, drain, take, in_range, full;

  loader_sync_edge u_sync_uploading (
    .clk  (clk),
    .d    (uploading),
    .level(up_level),
    .rise (up_rise),
    .fall (up_fall)
  );

  loader_sync_edge u_sync_strobe (
    .clk  (clk),
    .d    (upload_clk),
    .level(stb_level),
    .rise (stb_rise),
    .fall (stb_fall)
  );

  assign sync_unused = stb_level ^ stb_fall ^ up_fall;

  assign start    = up_rise && (state == ST_IDLE || state == ST_RESET);
  assign drain    = (state == ST_LOAD) && pend_valid;
  assign take     = stb_rise && upload_en && (state == ST_CLEAR || state == ST_LOAD);
  assign in_range = upload_a <= (ADDR_TOP - LOAD_BASE);
  assign full     = pend_valid && !drain;

  // Leaving LOAD tests the synchronised level, so a fall seen during CLEAR is honoured later.
  always_comb begin
    state_nxt = state;
    mem_busy  = 1'b0;
    cpu_res   = 1'b1;
    unique case (state)
      ST_IDLE: begin
        cpu_res = 1'b0;
        if (start) state_nxt = START_STATE;
      end
      ST_CLEAR: begin
        mem_busy = 1'b1;
        if (clr_a == ADDR_TOP) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        mem_busy = 1'b1;
        if (!up_level && !pend_valid) state_nxt = ST_RESET;
      end
      ST_RESET: begin
        if (start) state_nxt = START_STATE;
        else if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state        <= ST_RESET;
      hold_cnt     <= '0;
      pend_valid   <= 1'b0;
      pend_a       <= '0;
      pend_d       <= '0;
      clr_a        <= LOAD_BASE;
      mem_we       <= 1'b0;
      mem_a        <= '0;
      mem_d        <= '0;
      bytes_loaded <= '0;
      overflow     <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;
      if (state == ST_RESET && state_nxt == ST_RESET) hold_cnt <= hold_cnt + 16'd1;
      else hold_cnt <= '0;

      if (start) begin
        clr_a        <= LOAD_BASE;
        bytes_loaded <= '0;
        overflow     <= 1'b0;
        pend_valid   <= 1'b0;
      end else begin
        if (state == ST_CLEAR) begin
          mem_we <= 1'b1;
          mem_a  <= clr_a;
          mem_d  <= '0;
          clr_a  <= clr_a + 12'd1;
        end
        if (drain) begin
          mem_we       <= 1'b1;
          mem_a        <= pend_a;
          mem_d        <= pend_d;
          bytes_loaded <= bytes_loaded + 12'd1;
        end
        // A drain in the same cycle frees the slot, so the new byte is accepted.
        if (take && in_range && !full) begin
          pend_valid <= 1'b1;
          pend_a     <= LOAD_BASE + upload_a;
          pend_d     <= upload_d;
        end else if (drain) begin
          pend_valid <= 1'b0;
        end
        if (take && (!in_range || full)) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_program_loader.sv
// Directed/randomised bench for chip8_program_loader against a RAM-image reference model.
module tb_chip8_program_loader;

  localparam int BASE = 512;

  logic        clk = 1'b0;
  logic        res, uploading, upload_clk, upload_en;
  logic [11:0] upload_a;
  logic [7:0]  upload_d;

  logic        mem_busy, mem_we, cpu_res, overflow;
  logic [11:0] mem_a, bytes_loaded;
  logic [7:0]  mem_d;
  logic        nc_mem_busy, nc_mem_we, nc_cpu_res, nc_overflow;
  logic [11:0] nc_mem_a, nc_bytes_loaded;
  logic [7:0]  nc_mem_d;

  always #5 clk = ~clk;

  chip8_program_loader #(.LOAD_BASE(12'h200), .CLEAR_ON_START(1'b1), .RESET_HOLD(16)) dut (
    .clk(clk), .res(res), .uploading(uploading), .upload_clk(upload_clk),
    .upload_en(upload_en), .upload_a(upload_a), .upload_d(upload_d),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
    .cpu_res(cpu_res), .bytes_loaded(bytes_loaded), .overflow(overflow)
  );

  chip8_program_loader #(.LOAD_BASE(12'h200), .CLEAR_ON_START(1'b0), .RESET_HOLD(16)) dut_nc (
    .clk(clk), .res(res), .uploading(uploading), .upload_clk(upload_clk),
    .upload_en(upload_en), .upload_a(upload_a), .upload_d(upload_d),
    .mem_busy(nc_mem_busy), .mem_we(nc_mem_we), .mem_a(nc_mem_a), .mem_d(nc_mem_d),
    .cpu_res(nc_cpu_res), .bytes_loaded(nc_bytes_loaded), .overflow(nc_overflow)
  );

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, nc_we_cnt = 0, busy_viol = 0;
  int exp_cnt;
  logic exp_ovf;
  logic [7:0] sh_ram [4096];
  logic [7:0] sh_nc  [4096];
  logic [7:0] exp_ram[4096];

  always @(negedge clk) begin
    if (mem_we) begin
      sh_ram[mem_a] = mem_d;
      we_cnt++;
      if (!mem_busy) busy_viol++;
    end
    if (nc_mem_we) begin
      sh_nc[nc_mem_a] = nc_mem_d;
      nc_we_cnt++;
      if (!nc_mem_busy) busy_viol++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference model: the RAM image and counters implied by the upload rules.
  task automatic model_clear();
    for (int i = BASE; i < 4096; i++) exp_ram[i] = 8'h00;
  endtask

  task automatic model_byte(input logic [11:0] a, input logic [7:0] d, input logic en);
    int idx;
    idx = int'(a) + BASE;
    if (en) begin
      if (idx > 4095) exp_ovf = 1'b1;
      else begin
        exp_ram[idx] = d;
        exp_cnt++;
      end
    end
  endtask

  task automatic strobe(input logic [11:0] a, input logic [7:0] d, input logic en);
    upload_a  = a;
    upload_d  = d;
    upload_en = en;
    #($urandom_range(1, 3));
    upload_clk = 1'b1;
    tick(5);
    upload_clk = 1'b0;
    tick(5);
  endtask

  task automatic begin_upload();
    we_cnt    = 0;
    exp_cnt   = 0;
    exp_ovf   = 1'b0;
    model_clear();
    uploading = 1'b1;
  endtask

  task automatic wait_busy(input logic want, input string tag);
    int n;
    n = 0;
    while (mem_busy !== want && n < 200) begin
      tick(1);
      n++;
    end
    chk(tag, n >= 200, 0);
  endtask

  task automatic wait_clear_done(input string tag);
    int n;
    n = 0;
    while (!(mem_we === 1'b1 && mem_a === 12'hFFF) && n < 5000) begin
      tick(1);
      n++;
    end
    chk(tag, n >= 5000, 0);
    tick(4);
  endtask

  task automatic count_hold(input string tag);
    int n;
    n = 0;
    while (cpu_res === 1'b1 && n < 200) begin
      n++;
      tick(1);
    end
    chk(tag, n, 16);
  endtask

  task automatic end_upload(input string tag);
    uploading = 1'b0;
    wait_busy(1'b0, {tag, "_busy_drop"});
    count_hold({tag, "_hold"});
  endtask

  task automatic cmp_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++) if (sh_ram[i] !== exp_ram[i]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    logic [11:0] a0, a1, a2;
    logic [7:0]  d0, d1, d2;
    int snap;

    res = 1'b1; uploading = 1'b0; upload_clk = 1'b0;
    upload_en = 1'b0; upload_a = '0; upload_d = '0;
    for (int i = 0; i < 4096; i++) begin
      sh_ram[i]  = 8'h55;
      exp_ram[i] = 8'h55;
      sh_nc[i]   = 8'h5A;
    end

    // 1: reset values and post-reset CPU hold
    tick(4);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_d", mem_d, 0);
    chk("rst_mem_busy", mem_busy, 0);
    chk("rst_cpu_res", cpu_res, 1);
    chk("rst_bytes", bytes_loaded, 0);
    chk("rst_overflow", overflow, 0);
    res = 1'b0;
    count_hold("rst_hold");

    // 2: three fixed bytes after a full clear
    begin_upload();
    wait_busy(1'b1, "t2_busy");
    wait_clear_done("t2_clear");
    strobe(12'h000, 8'hA2, 1'b1); model_byte(12'h000, 8'hA2, 1'b1);
    strobe(12'h001, 8'h1E, 1'b1); model_byte(12'h001, 8'h1E, 1'b1);
    strobe(12'h002, 8'hFF, 1'b1); model_byte(12'h002, 8'hFF, 1'b1);
    tick(4);
    chk("t2_bytes", bytes_loaded, exp_cnt);
    chk("t2_overflow", overflow, exp_ovf);
    end_upload("t2");
    chk("t2_writes", we_cnt, 3584 + exp_cnt);
    chk("t2_ram_200", sh_ram[12'h200], 8'hA2);
    cmp_ram("t2_ram");

    // 3: range boundary plus random in-range bytes
    begin_upload();
    wait_busy(1'b1, "t3_busy");
    wait_clear_done("t3_clear");
    repeat (4) begin
      a0 = 12'($urandom_range(0, 12'hDFE));
      d0 = 8'($urandom);
      strobe(a0, d0, 1'b1); model_byte(a0, d0, 1'b1);
    end
    chk("t3_ovf_before", overflow, 0);
    d0 = 8'($urandom);
    strobe(12'hE00, d0, 1'b1); model_byte(12'hE00, d0, 1'b1);
    chk("t3_ovf_e00", overflow, exp_ovf);
    a0 = 12'($urandom_range(12'hE01, 12'hFFF));
    strobe(a0, 8'($urandom), 1'b1); model_byte(a0, 8'h00, 1'b1);
    d1 = 8'($urandom);
    strobe(12'hDFF, d1, 1'b1); model_byte(12'hDFF, d1, 1'b1);
    tick(4);
    chk("t3_bytes", bytes_loaded, exp_cnt);
    chk("t3_ovf_sticky", overflow, exp_ovf);
    end_upload("t3");
    chk("t3_ram_fff", sh_ram[12'hFFF], d1);
    cmp_ram("t3_ram");

    // 4: two strobes while clearing: first held, second dropped
    begin_upload();
    wait_busy(1'b1, "t4_busy");
    a0 = 12'($urandom_range(0, 12'hDFF)); d0 = 8'($urandom);
    a1 = 12'($urandom_range(0, 12'hDFF)); d1 = 8'($urandom);
    strobe(a0, d0, 1'b1); model_byte(a0, d0, 1'b1);
    strobe(a1, d1, 1'b1); exp_ovf = 1'b1;
    chk("t4_busy_mid", mem_busy, 1);
    chk("t4_ovf_clear", overflow, exp_ovf);
    wait_clear_done("t4_clear");
    chk("t4_bytes", bytes_loaded, exp_cnt);
    end_upload("t4");
    chk("t4_writes", we_cnt, 3584 + exp_cnt);
    cmp_ram("t4_ram");

    // 5: res mid-LOAD aborts; later strobes are ignored
    begin_upload();
    wait_busy(1'b1, "t5_busy");
    wait_clear_done("t5_clear");
    strobe(12'($urandom_range(0, 12'hDFF)), 8'($urandom), 1'b1);
    chk("t5_bytes_pre", bytes_loaded, 1);
    res = 1'b1;
    tick(1);
    chk("t5_busy_after_res", mem_busy, 0);
    chk("t5_cpu_res", cpu_res, 1);
    res = 1'b0;
    snap = we_cnt;
    strobe(12'($urandom_range(0, 12'hDFF)), 8'($urandom), 1'b1);
    strobe(12'($urandom_range(0, 12'hDFF)), 8'($urandom), 1'b1);
    chk("t5_no_writes", we_cnt - snap, 0);
    chk("t5_bytes_post", bytes_loaded, 0);
    uploading = 1'b0;
    tick(40);

    // 6: no-clear variant, one strobe without upload_en
    nc_we_cnt = 0;
    a0 = 12'($urandom_range(0, 12'h3FF));
    a1 = a0 + 12'h400;
    a2 = a0 + 12'h800;
    d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
    uploading = 1'b1;
    snap = 0;
    while (nc_mem_busy !== 1'b1 && snap < 200) begin
      tick(1);
      snap++;
    end
    chk("t6_busy", snap >= 200, 0);
    strobe(a0, d0, 1'b1);
    strobe(a1, d1, 1'b0);
    strobe(a2, d2, 1'b1);
    tick(4);
    chk("t6_bytes", nc_bytes_loaded, 2);
    chk("t6_writes", nc_we_cnt, 2);
    chk("t6_ram_a0", sh_nc[int'(a0) + BASE], d0);
    chk("t6_ram_a1", sh_nc[int'(a1) + BASE], 8'h5A);
    chk("t6_ram_a2", sh_nc[int'(a2) + BASE], d2);
    uploading = 1'b0;
    tick(40);
    chk("t6_busy_end", nc_mem_busy, 0);

    chk("we_without_busy", busy_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
